lock_code_sender: RTL and testbench

Drives the button-side of the three-button digital lock: on a Start request it plays a stored code as one-hot, single-cycle A/B/C presses with fixed spacing. It then watches the lock's Unlock/Alarm outputs and reports Pass, Fail or TimedOut. It sits between the test/host controller and the lock FSM, on the same clock.

---
 rtl/lock_pkg.sv | 42 ++++
 rtl/lock_resp_monitor.sv | 56 +++++
 rtl/lock_code_sender.sv | 168 ++++++++++++++++
 tb/tb_lock_code_sender.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the three-button lock and its code sender.
// Holds symbol encodings, the sender FSM state type, monitor result codes,
// the lock's correct code and a symbol-to-button decode helper.
package lock_pkg;

    // 2-bit code symbols; blank consumes a press slot without a button.
    localparam logic [1:0] SYM_BLANK = 2'b00;
    localparam logic [1:0] SYM_A     = 2'b01;
    localparam logic [1:0] SYM_B     = 2'b10;
    localparam logic [1:0] SYM_C     = 2'b11;

    // Code that opens the lock: B, C, A, C (symbol 0 in bits [1:0]).
    localparam logic [7:0] LOCK_CODE = 8'hDE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2,
        ST_WAIT  = 2'd3
    } sender_state_t;

    typedef enum logic [1:0] {
        RES_NONE    = 2'd0,
        RES_PASS    = 2'd1,
        RES_FAIL    = 2'd2,
        RES_TIMEOUT = 2'd3
    } resp_t;

    // Decode a symbol to one-hot buttons, returned as {C, B, A}.
    function automatic logic [2:0] sym_to_btn(input logic [1:0] sym);
        logic [2:0] btn;
        btn = 3'b000;
        case (sym)
            SYM_A:   btn = 3'b001;
            SYM_B:   btn = 3'b010;
            SYM_C:   btn = 3'b100;
            default: btn = 3'b000;
        endcase
        return btn;
    endfunction

endpackage

// File: rtl/lock_resp_monitor.sv
// Watches the lock's Unlock/Alarm while the sender is in WAIT.
// Ports: clk_i, rst_i, en_i (sender in WAIT), unlock_i, alarm_i in;
//        hit_o (result available this cycle), res_o (result code) out.
// Flags are ignored for the first SETTLE WAIT cycles; Alarm beats Unlock;
// a TimedOut hit is raised in WAIT cycle TIMEOUT-1 if nothing else hit.
module lock_resp_monitor
    import lock_pkg::*;
#(
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 8
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  en_i,
    input  logic  unlock_i,
    input  logic  alarm_i,
    output logic  hit_o,
    output resp_t res_o
);

    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [WW-1:0] w_q;
    logic          sample_ok;

    assign sample_ok = (w_q >= WW'(SETTLE));

    always_comb begin
        hit_o = 1'b0;
        res_o = RES_NONE;
        if (en_i) begin
            if (sample_ok && alarm_i) begin
                hit_o = 1'b1;
                res_o = RES_FAIL;
            end else if (sample_ok && unlock_i) begin
                hit_o = 1'b1;
                res_o = RES_PASS;
            end else if (w_q == WW'(TIMEOUT - 1)) begin
                hit_o = 1'b1;
                res_o = RES_TIMEOUT;
            end
        end
    end

    // Counter restarts from 0 on every entry into WAIT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_q <= '0;
        end else if (!en_i || hit_o) begin
            w_q <= '0;
        end else begin
            w_q <= w_q + 1'b1;
        end
    end

endmodule

// File: rtl/lock_code_sender.sv
// Plays a stored code into the lock as single-cycle one-hot A/B/C presses
// spaced by GAP idle cycles, then reports Pass/Fail/TimedOut from the lock.
// Ports: clk_i, rst_i, start_i, code_i, unlock_i, alarm_i in; a_o/b_o/c_o,
//        busy_o, done_o, pass_o, fail_o, timed_out_o out (all registered).
// Optional LOCK_SENDER_ABORT_EN adds abort_i / aborted_o.
module lock_code_sender
    import lock_pkg::*;
#(
    parameter int CODE_LEN = 4,
    parameter int GAP      = 2,
    parameter int SETTLE   = 2,
    parameter int TIMEOUT  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [2*CODE_LEN-1:0] code_i,
    input  logic                  unlock_i,
    input  logic                  alarm_i,
    output logic                  a_o,
    output logic                  b_o,
    output logic                  c_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  fail_o,
    output logic                  timed_out_o
`ifdef LOCK_SENDER_ABORT_EN
    ,
    input  logic                  abort_i,
    output logic                  aborted_o
`endif
);

    localparam int IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    sender_state_t         state_q;
    logic [2*CODE_LEN-1:0] code_q;   // remaining symbols, next one in [1:0]
    logic [IW-1:0]         idx_q;    // index of the symbol being played
    logic [GW-1:0]         gap_q;
    logic [2:0]            btn_q;    // {C, B, A}
    logic                  busy_q, done_q, pass_q, fail_q, tmo_q;
    logic                  hit;
    resp_t                 res;
    logic                  abort_w;
    logic                  last_sym;

`ifdef LOCK_SENDER_ABORT_EN
    logic aborted_q;
    assign abort_w   = abort_i;
    assign aborted_o = aborted_q;
`else
    assign abort_w = 1'b0;
`endif

    assign last_sym = (idx_q == IW'(CODE_LEN - 1));

    lock_resp_monitor #(
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) u_mon (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (state_q == ST_WAIT),
        .unlock_i (unlock_i),
        .alarm_i  (alarm_i),
        .hit_o    (hit),
        .res_o    (res)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            btn_q   <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            tmo_q   <= 1'b0;
`ifdef LOCK_SENDER_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (abort_w && state_q != ST_IDLE) begin
                // Abort wins over a result arriving in the same cycle.
                btn_q   <= 3'b000;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
`ifdef LOCK_SENDER_ABORT_EN
                aborted_q <= 1'b1;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i) begin
                            btn_q   <= sym_to_btn(code_i[1:0]);
                            code_q  <= {2'b00, code_i[2*CODE_LEN-1:2]};
                            idx_q   <= '0;
                            busy_q  <= 1'b1;
                            pass_q  <= 1'b0;
                            fail_q  <= 1'b0;
                            tmo_q   <= 1'b0;
                            state_q <= ST_PRESS;
`ifdef LOCK_SENDER_ABORT_EN
                            aborted_q <= 1'b0;
`endif
                        end
                    end
                    ST_PRESS: begin
                        if (GAP > 0) begin
                            btn_q   <= 3'b000;
                            gap_q   <= '0;
                            state_q <= ST_GAP;
                        end else if (last_sym) begin
                            btn_q   <= 3'b000;
                            state_q <= ST_WAIT;
                        end else begin
                            btn_q  <= sym_to_btn(code_q[1:0]);
                            code_q <= {2'b00, code_q[2*CODE_LEN-1:2]};
                            idx_q  <= idx_q + 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (gap_q == GW'(GAP - 1)) begin
                            if (last_sym) begin
                                state_q <= ST_WAIT;
                            end else begin
                                btn_q   <= sym_to_btn(code_q[1:0]);
                                code_q  <= {2'b00, code_q[2*CODE_LEN-1:2]};
                                idx_q   <= idx_q + 1'b1;
                                state_q <= ST_PRESS;
                            end
                        end else begin
                            gap_q <= gap_q + 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (hit) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            pass_q  <= (res == RES_PASS);
                            fail_q  <= (res == RES_FAIL);
                            tmo_q   <= (res == RES_TIMEOUT);
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign a_o         = btn_q[0];
    assign b_o         = btn_q[1];
    assign c_o         = btn_q[2];
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign timed_out_o = tmo_q;

endmodule

// File: tb/tb_lock_code_sender.sv
// Directed bench for lock_code_sender with a small behavioural lock model.
// Default parameters: CODE_LEN=4, GAP=2, SETTLE=2, TIMEOUT=8.
// Start accepted at edge k: presses at k, k+3, k+6, k+9; WAIT from k+12;
// earliest result edge k+15; TimedOut edge k+20.
module tb_lock_code_sender;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] code = 8'h00;
    logic       unlock_w, alarm_w;
    logic       a_o, b_o, c_o, busy_o, done_o, pass_o, fail_o, tmo_o;
`ifdef LOCK_SENDER_ABORT_EN
    logic       aborted_o;
`endif

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int ecnt     = 0;

    // Input override for forced-flag scenarios.
    logic force_en = 1'b0, f_unlock = 1'b0, f_alarm = 1'b0;

    // Lock model: correct sequence B,C,A,C unlocks; third wrong press alarms.
    logic       lock_rst = 1'b0;
    logic [7:0] lock_code = 8'hDE;
    int         m_idx = 0, m_err = 0;
    logic       m_unl = 1'b0, m_alm = 1'b0;
    logic [1:0] press_sym, want_sym;

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    always_comb begin
        press_sym = 2'b00;
        if (a_o) press_sym = 2'b01;
        if (b_o) press_sym = 2'b10;
        if (c_o) press_sym = 2'b11;
        want_sym = 2'((lock_code >> (2 * m_idx)) & 8'h03);
    end

    always @(posedge clk) begin
        if (lock_rst) begin
            m_idx <= 0; m_err <= 0; m_unl <= 1'b0; m_alm <= 1'b0;
        end else if (!m_unl && !m_alm && (a_o || b_o || c_o)) begin
            if (press_sym == want_sym) begin
                if (m_idx == 3) m_unl <= 1'b1;
                else            m_idx <= m_idx + 1;
            end else begin
                m_idx <= 0;
                if (m_err == 2) m_alm <= 1'b1;
                m_err <= m_err + 1;
            end
        end
    end

    assign unlock_w = force_en ? f_unlock : m_unl;
    assign alarm_w  = force_en ? f_alarm  : m_alm;

    lock_code_sender dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .code_i      (code),
        .unlock_i    (unlock_w),
        .alarm_i     (alarm_w),
        .a_o         (a_o),
        .b_o         (b_o),
        .c_o         (c_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .fail_o      (fail_o),
        .timed_out_o (tmo_o)
`ifdef LOCK_SENDER_ABORT_EN
        ,
        .abort_i     (1'b0),
        .aborted_o   (aborted_o)
`endif
    );

    task automatic reset_lock();
        lock_rst = 1'b1;
        @(negedge clk);
        lock_rst = 1'b0;
    endtask

    // Returns k = the edge at which Start was accepted; ends at negedge after k.
    task automatic start_seq(input logic [7:0] c, output int k);
        @(negedge clk);
        code  = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = ecnt;
    endtask

    // Waits (bounded) for Done; stays at the negedge where Done is seen.
    task automatic wait_done(input int maxc, output int e, output bit ok);
        ok = 1'b0;
        e  = -1;
        for (int i = 0; i < maxc; i++) begin
            if (done_o) begin
                ok = 1'b1;
                e  = ecnt;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tot_cnt++;
        if ({a_o, b_o, c_o, busy_o, done_o, pass_o, fail_o, tmo_o} !== 8'h00)
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {a_o, b_o, c_o, busy_o, done_o, pass_o, fail_o, tmo_o});
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        tot_cnt++;
        if ({a_o, b_o, c_o, busy_o, done_o, pass_o, fail_o, tmo_o} !== 8'h00)
            $display("FAIL post_reset_idle: got %b expected 00000000",
                     {a_o, b_o, c_o, busy_o, done_o, pass_o, fail_o, tmo_o});
        else pass_cnt++;
    endtask

    task automatic test_pass();
        int k, e;
        bit ok;
        logic [2:0] exp_btn [4];
        logic [2:0] expv;
        exp_btn[0] = 3'b010;  // B  ({C,B,A})
        exp_btn[1] = 3'b100;  // C
        exp_btn[2] = 3'b001;  // A
        exp_btn[3] = 3'b100;  // C
        force_en = 1'b0;
        reset_lock();
        start_seq(8'hDE, k);
        tot_cnt++;
        if (busy_o !== 1'b1) $display("FAIL pass_busy_high: got %b expected 1", busy_o);
        else pass_cnt++;
        for (int j = 0; j < 12; j++) begin
            expv = (j % 3 == 0) ? exp_btn[j / 3] : 3'b000;
            tot_cnt++;
            if ({c_o, b_o, a_o} !== expv)
                $display("FAIL pass_buttons_cycle%0d: got %b expected %b", j, {c_o, b_o, a_o}, expv);
            else pass_cnt++;
            @(negedge clk);
        end
        wait_done(20, e, ok);
        tot_cnt++;
        if (ok !== 1'b1) $display("FAIL pass_done_seen: got %b expected 1", ok);
        else pass_cnt++;
        tot_cnt++;
        if (e !== k + 15) $display("FAIL pass_done_edge: got %0d expected %0d", e - k, 15);
        else pass_cnt++;
        tot_cnt++;
        if ({pass_o, fail_o, tmo_o, busy_o} !== 4'b1000)
            $display("FAIL pass_result: got %b expected 1000", {pass_o, fail_o, tmo_o, busy_o});
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if ({done_o, pass_o} !== 2'b01)
            $display("FAIL pass_done_one_cycle: got %b expected 01", {done_o, pass_o});
        else pass_cnt++;
    endtask

    task automatic test_alarm();
        int k, e;
        bit ok;
        force_en = 1'b0;
        reset_lock();
        start_seq(8'h55, k);
        tot_cnt++;
        if (pass_o !== 1'b0) $display("FAIL alarm_flags_cleared: got %b expected 0", pass_o);
        else pass_cnt++;
        wait_done(40, e, ok);
        tot_cnt++;
        if (ok !== 1'b1) $display("FAIL alarm_done_seen: got %b expected 1", ok);
        else pass_cnt++;
        tot_cnt++;
        if ({pass_o, fail_o, tmo_o} !== 3'b010)
            $display("FAIL alarm_result: got %b expected 010", {pass_o, fail_o, tmo_o});
        else pass_cnt++;
    endtask

    task automatic test_both_forced();
        int k, e;
        bit ok;
        force_en = 1'b1; f_unlock = 1'b1; f_alarm = 1'b1;
        start_seq(8'hDE, k);
        tot_cnt++;
        if (fail_o !== 1'b0) $display("FAIL both_flags_cleared: got %b expected 0", fail_o);
        else pass_cnt++;
        wait_done(40, e, ok);
        tot_cnt++;
        if (e !== k + 15) $display("FAIL both_done_edge: got %0d expected %0d", e - k, 15);
        else pass_cnt++;
        tot_cnt++;
        if ({pass_o, fail_o, tmo_o} !== 3'b010)
            $display("FAIL both_alarm_priority: got %b expected 010", {pass_o, fail_o, tmo_o});
        else pass_cnt++;
        f_unlock = 1'b0; f_alarm = 1'b0;
    endtask

    task automatic test_timeout();
        int k, e, n;
        force_en = 1'b1; f_unlock = 1'b0; f_alarm = 1'b0;
        start_seq(8'hDE, k);
        for (int i = 0; i < 20 && ecnt < k + 12; i++) @(negedge clk);
        // Unlock high only in WAIT cycles w=0 and w=1.
        f_unlock = 1'b1;
        @(negedge clk);
        @(negedge clk);
        f_unlock = 1'b0;
        n = 0; e = -1;
        for (int i = 0; i < 15; i++) begin
            if (done_o) begin n++; e = ecnt; end
            @(negedge clk);
        end
        tot_cnt++;
        if (n !== 1) $display("FAIL timeout_done_count: got %0d expected 1", n);
        else pass_cnt++;
        tot_cnt++;
        if (e !== k + 20) $display("FAIL timeout_done_edge: got %0d expected %0d", e - k, 20);
        else pass_cnt++;
        tot_cnt++;
        if ({pass_o, fail_o, tmo_o} !== 3'b001)
            $display("FAIL timeout_result: got %b expected 001", {pass_o, fail_o, tmo_o});
        else pass_cnt++;
    endtask

    task automatic test_blank_and_busy_start();
        int k, e, n;
        logic any_btn;
        force_en = 1'b1; f_unlock = 1'b0; f_alarm = 1'b0;
        start_seq(8'h00, k);
        any_btn = 1'b0;
        for (int j = 0; j < 12; j++) begin
            any_btn = any_btn | a_o | b_o | c_o;
            start = (j == 5);  // Start while busy must be ignored
            code  = 8'hDE;
            @(negedge clk);
        end
        start = 1'b0;
        n = 0; e = -1;
        for (int i = 0; i < 20; i++) begin
            any_btn = any_btn | a_o | b_o | c_o;
            if (done_o) begin n++; e = ecnt; end
            @(negedge clk);
        end
        tot_cnt++;
        if (any_btn !== 1'b0) $display("FAIL blank_no_buttons: got %b expected 0", any_btn);
        else pass_cnt++;
        tot_cnt++;
        if (n !== 1) $display("FAIL blank_single_done: got %0d expected 1", n);
        else pass_cnt++;
        tot_cnt++;
        if (e !== k + 20) $display("FAIL blank_timeout_edge: got %0d expected %0d", e - k, 20);
        else pass_cnt++;
        tot_cnt++;
        if ({tmo_o, busy_o} !== 2'b10)
            $display("FAIL blank_idle_after: got %b expected 10", {tmo_o, busy_o});
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int k, k2;
        force_en = 1'b1; f_unlock = 1'b0; f_alarm = 1'b0;
        start_seq(8'hDE, k);
        for (int i = 0; i < 10 && ecnt < k + 4; i++) @(negedge clk);
        rst = 1'b1;
        #1;
        tot_cnt++;
        if ({a_o, b_o, c_o, busy_o, done_o, pass_o, fail_o, tmo_o} !== 8'h00)
            $display("FAIL midreset_async_clear: got %b expected 00000000",
                     {a_o, b_o, c_o, busy_o, done_o, pass_o, fail_o, tmo_o});
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        start_seq(8'hDE, k2);
        tot_cnt++;
        if ({c_o, b_o, a_o, busy_o} !== 4'b0101)
            $display("FAIL midreset_replay_sym0: got %b expected 0101", {c_o, b_o, a_o, busy_o});
        else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        tot_cnt++;
        if ({c_o, b_o, a_o} !== 3'b100)
            $display("FAIL midreset_replay_sym1: got %b expected 100", {c_o, b_o, a_o});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_pass();
        test_alarm();
        test_both_forced();
        test_timeout();
        test_blank_and_busy_start();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
